// File: rtl/regfile_wb_sched.sv
// Write-port scheduler for the GPR file: arbitrates two write-back
// sources and keeps the per-register busy scoreboard for ID hazards.
`ifndef GPR_ADDR_SPACE
`define GPR_ADDR_SPACE 5
`endif
`ifndef GPR_WIDTH
`define GPR_WIDTH 32
`endif
`ifndef GPR_NUM
`define GPR_NUM 32
`endif

module regfile_wb_sched #(
  parameter int ADDR_W       = `GPR_ADDR_SPACE,
  parameter int DATA_W       = `GPR_WIDTH,
  parameter int NREG         = `GPR_NUM,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              iss_valid_i,
  input  logic [ADDR_W-1:0] iss_rs1_i,
  input  logic [ADDR_W-1:0] iss_rs2_i,
  input  logic [ADDR_W-1:0] iss_rd_i,
  input  logic              iss_rd_we_i,
  input  logic              iss_use_rs2_i,
  output logic              iss_stall_o,
  input  logic              wba_valid_i,
  input  logic [ADDR_W-1:0] wba_addr_i,
  input  logic [DATA_W-1:0] wba_data_i,
  output logic              wba_ready_o,
  input  logic              wbb_valid_i,
  input  logic [ADDR_W-1:0] wbb_addr_i,
  input  logic [DATA_W-1:0] wbb_data_i,
  output logic              wbb_ready_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [DATA_W-1:0] rd_val_o,
  output logic              rd_we_o,
  output logic [NREG-1:0]   busy_o
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [NREG-1:0]   busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] val_q, val_d;

  logic              force_b;
  logic              grant;
  logic              issue;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_data;

  // x0 and out-of-range indices never read as busy
  function automatic logic is_busy(
    input logic [NREG-1:0]   b,
    input logic [ADDR_W-1:0] a
  );
    logic r;
    r = 1'b0;
    for (int i = 1; i < NREG; i++)
      if (a == ADDR_W'(i)) r = b[i];
    return r;
  endfunction

  assign iss_stall_o = iss_valid_i & (
    is_busy(busy_q, iss_rs1_i) |
    (iss_use_rs2_i & is_busy(busy_q, iss_rs2_i)) |
    (iss_rd_we_i & is_busy(busy_q, iss_rd_i)));

  assign issue = iss_valid_i & ~iss_stall_o & iss_rd_we_i &
                 (iss_rd_i != '0);

  assign force_b = wbb_valid_i &
                   (cnt_q == CNT_W'(STARVE_LIMIT));
  assign wba_ready_o = wba_valid_i & ~force_b;
  assign wbb_ready_o = wbb_valid_i & (~wba_valid_i | force_b);
  assign grant = wba_ready_o | wbb_ready_o;
  assign g_addr = wba_ready_o ? wba_addr_i : wbb_addr_i;
  assign g_data = wba_ready_o ? wba_data_i : wbb_data_i;

  always_comb begin
    cnt_d = cnt_q;
    if (!wbb_valid_i || wbb_ready_o)
      cnt_d = '0;
    else if (cnt_q != CNT_W'(STARVE_LIMIT))
      cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    we_d   = grant & (g_addr != '0);
    addr_d = grant ? g_addr : addr_q;
    val_d  = grant ? g_data : val_q;
  end

  // clear before set so a same-edge issue to that index wins
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < NREG; i++) begin
      if (grant && g_addr == ADDR_W'(i)) busy_d[i] = 1'b0;
      if (issue && iss_rd_i == ADDR_W'(i)) busy_d[i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      busy_q <= '0;
      cnt_q  <= '0;
      we_q   <= 1'b0;
      addr_q <= '0;
      val_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      val_q  <= val_d;
    end
  end

  assign rd_we_o   = we_q;
  assign rd_addr_o = addr_q;
  assign rd_val_o  = val_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Bench for regfile_wb_sched: directed scenarios, a behavioural
// scoreboard model checked every cycle, plus literal expectations.
module tb_regfile_wb_sched;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 32;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          iss_valid = 1'b0;
  logic [AW-1:0] iss_rs1 = '0, iss_rs2 = '0, iss_rd = '0;
  logic          iss_rd_we = 1'b0, iss_use_rs2 = 1'b0;
  logic          iss_stall;
  logic          wba_valid = 1'b0;
  logic [AW-1:0] wba_addr = '0;
  logic [DW-1:0] wba_data = '0;
  logic          wba_ready;
  logic          wbb_valid = 1'b0;
  logic [AW-1:0] wbb_addr = '0;
  logic [DW-1:0] wbb_data = '0;
  logic          wbb_ready;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_val;
  logic          rd_we;
  logic [NR-1:0] busy;

  regfile_wb_sched #(
    .ADDR_W(AW), .DATA_W(DW), .NREG(NR), .STARVE_LIMIT(SL)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .iss_valid_i(iss_valid), .iss_rs1_i(iss_rs1),
    .iss_rs2_i(iss_rs2), .iss_rd_i(iss_rd),
    .iss_rd_we_i(iss_rd_we), .iss_use_rs2_i(iss_use_rs2),
    .iss_stall_o(iss_stall),
    .wba_valid_i(wba_valid), .wba_addr_i(wba_addr),
    .wba_data_i(wba_data), .wba_ready_o(wba_ready),
    .wbb_valid_i(wbb_valid), .wbb_addr_i(wbb_addr),
    .wbb_data_i(wbb_data), .wbb_ready_o(wbb_ready),
    .rd_addr_o(rd_addr), .rd_val_o(rd_val), .rd_we_o(rd_we),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model: set of in-flight destinations, starvation age, last write
  bit            m_busy[NR];
  int            m_age = 0;
  bit            m_we = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_val = '0;

  function automatic bit m_isb(input logic [AW-1:0] a);
    return (a != 0) && m_busy[a];
  endfunction

  function automatic bit m_stall();
    if (!iss_valid) return 0;
    return m_isb(iss_rs1) || (iss_use_rs2 && m_isb(iss_rs2)) ||
           (iss_rd_we && m_isb(iss_rd));
  endfunction

  function automatic bit m_bwins();
    // B wins if A is absent, or B has already waited its full budget
    return wbb_valid && (!wba_valid || m_age >= SL);
  endfunction

  function automatic bit m_awins();
    return wba_valid && !m_bwins();
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      foreach (m_busy[i]) m_busy[i] = 0;
      m_age = 0; m_we = 0; m_addr = '0; m_val = '0;
    end else begin
      bit ga, gb, iss;
      logic [AW-1:0] wa;
      ga = m_awins();
      gb = m_bwins();
      iss = iss_valid && !m_stall() && iss_rd_we && iss_rd != 0;
      if (ga || gb) begin
        wa = ga ? wba_addr : wbb_addr;
        m_we = (wa != 0);
        m_addr = wa;
        m_val = ga ? wba_data : wbb_data;
        m_busy[wa] = 0;
      end else
        m_we = 0;
      if (iss) m_busy[iss_rd] = 1;
      if (wbb_valid && !gb)
        m_age = (m_age < SL) ? m_age + 1 : m_age;
      else
        m_age = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [NR-1:0] mb;
      for (int i = 0; i < NR; i++) mb[i] = m_busy[i];
      chk("cmp_stall", 32'(iss_stall), 32'(m_stall()));
      chk("cmp_a_ready", 32'(wba_ready), 32'(m_awins()));
      chk("cmp_b_ready", 32'(wbb_ready), 32'(m_bwins()));
      chk("cmp_rd_we", 32'(rd_we), 32'(m_we));
      chk("cmp_rd_addr", 32'(rd_addr), 32'(m_addr));
      chk("cmp_rd_val", rd_val, m_val);
      chk("cmp_busy", busy, mb);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [AW-1:0] rd, input logic we,
                       input logic [AW-1:0] rs1,
                       input logic [AW-1:0] rs2, input logic u2);
    iss_valid = 1'b1; iss_rd = rd; iss_rd_we = we;
    iss_rs1 = rs1; iss_rs2 = rs2; iss_use_rs2 = u2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(); step();
    rst_n = 1'b1;
    chk_en = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_we", 32'(rd_we), 0);
    chk("rst_addr", 32'(rd_addr), 0);

    // RAW release on x5
    issue(5, 1, 1, 2, 1); #1;
    chk("raw_issue_stall", 32'(iss_stall), 0);
    step();
    chk("raw_busy5", 32'(busy[5]), 1);
    issue(6, 0, 5, 0, 0); #1;
    chk("raw_stall", 32'(iss_stall), 1);
    wba_valid = 1; wba_addr = 5; wba_data = 32'hDEADBEEF; #1;
    chk("raw_a_ready", 32'(wba_ready), 1);
    step();
    wba_valid = 0; #1;
    chk("raw_we", 32'(rd_we), 1);
    chk("raw_addr", 32'(rd_addr), 5);
    chk("raw_val", rd_val, 32'hDEADBEEF);
    chk("raw_busy5_clr", 32'(busy[5]), 0);
    chk("raw_release", 32'(iss_stall), 0);
    step();
    iss_valid = 0;

    // Fixed priority A over B
    wba_valid = 1; wba_addr = 3; wba_data = 32'h33;
    wbb_valid = 1; wbb_addr = 4; wbb_data = 32'h44; #1;
    chk("pri_a", 32'(wba_ready), 1);
    chk("pri_b_wait", 32'(wbb_ready), 0);
    step();
    wba_valid = 0; #1;
    chk("pri_b", 32'(wbb_ready), 1);
    chk("pri_first", 32'(rd_addr), 3);
    step();
    wbb_valid = 0;
    chk("pri_second", 32'(rd_addr), 4);
    chk("pri_second_val", rd_val, 32'h44);
    chk("pri_nonbusy", 32'(busy[3]), 0);
    step();
    chk("idle_we", 32'(rd_we), 0);
    chk("idle_hold", 32'(rd_addr), 4);

    // Starvation override
    wba_valid = 1; wba_addr = 10; wba_data = 32'hA0;
    wbb_valid = 1; wbb_addr = 11; wbb_data = 32'hB0;
    for (int i = 0; i < SL; i++) begin
      #1;
      chk("starve_refused", 32'(wbb_ready), 0);
      step();
    end
    #1;
    chk("starve_forced_b", 32'(wbb_ready), 1);
    chk("starve_a_held", 32'(wba_ready), 0);
    step();
    chk("starve_addr", 32'(rd_addr), 11);
    chk("starve_cnt_clr", 32'(wbb_ready), 0);
    wbb_valid = 0; step();
    wba_valid = 0; step();

    // x0 never busy, never written
    issue(0, 1, 0, 0, 0); #1;
    chk("x0_stall", 32'(iss_stall), 0);
    step();
    iss_valid = 0;
    chk("x0_busy", busy, 0);
    wba_valid = 1; wba_addr = 0; wba_data = 1; #1;
    chk("x0_ready", 32'(wba_ready), 1);
    step();
    wba_valid = 0;
    chk("x0_no_we", 32'(rd_we), 0);

    // WAW on x7
    issue(7, 1, 1, 1, 1); step();
    chk("waw_busy7", 32'(busy[7]), 1);
    #1;
    chk("waw_stall", 32'(iss_stall), 1);
    step();
    chk("waw_stall_hold", 32'(iss_stall), 1);
    wba_valid = 1; wba_addr = 7; wba_data = 32'h77; step();
    wba_valid = 0; #1;
    chk("waw_release", 32'(iss_stall), 0);
    chk("waw_busy7_clr", 32'(busy[7]), 0);
    chk("waw_we", 32'(rd_we), 1);
    step();
    iss_valid = 0;
    chk("waw_busy7_again", 32'(busy[7]), 1);

    // Same-edge set and clear of x9: set wins
    wba_valid = 1; wba_addr = 9; wba_data = 32'h99;
    issue(9, 1, 0, 0, 0); #1;
    chk("sc_stall", 32'(iss_stall), 0);
    step();
    iss_valid = 0; wba_valid = 0;
    chk("sc_set_wins", 32'(busy[9]), 1);
    chk("sc_we", 32'(rd_we), 1);
    step();

    // Reset during an active A grant
    issue(12, 1, 0, 0, 0); step();
    iss_valid = 0;
    wba_valid = 1; wba_addr = 6; wba_data = 32'h66;
    rst_n = 0; step();
    chk("rst_mid_we", 32'(rd_we), 0);
    step();
    rst_n = 1; wba_valid = 0;
    chk("rst2_we", 32'(rd_we), 0);
    chk("rst2_busy", busy, 0);
    chk("rst2_addr", 32'(rd_addr), 0);
    chk("rst2_val", rd_val, 0);
    step();
    chk("rst2_no_write", 32'(rd_we), 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
